pc_imem_fetch: RTL

PC_IMEM_FETCH -- requirements
Module: pc_imem_fetch

---
 rtl/pc_imem_pkg.sv | 26 ++
 rtl/imem_bytes.sv | 51 +++++
 rtl/pc_imem_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_imem_pkg.sv
// Shared definitions for the PC / instruction-memory fetch block.
//   fetch_state_e : fetch controller states
//   off_w()       : width of the in-instruction byte offset for a given size
//   instr_w()     : fetched word width for a given instruction size
// The *_DEF localparams give the values for the default 4-byte instruction.
package pc_imem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  function automatic int off_w(input int instr_bytes);
    return $clog2(instr_bytes);
  endfunction

  function automatic int instr_w(input int instr_bytes);
    return 8 * instr_bytes;
  endfunction

  localparam int INSTR_BYTES_DEF = 4;
  localparam int OFF_W_DEF       = off_w(INSTR_BYTES_DEF);
  localparam int INSTR_W_DEF     = instr_w(INSTR_BYTES_DEF);

endpackage

// File: rtl/imem_bytes.sv
// Byte-addressed instruction memory.
//   clock, reset_n : clock, async active-low reset (read register only)
//   we/waddr/wdata : one byte-write port, address taken mod DEPTH_BYTES
//   re/raddr       : read enable / byte address of the first byte
//   rdata          : INSTR_BYTES bytes, big-endian, registered (one-edge latency)
// Array contents are never reset so a loaded program survives reset.
import pc_imem_pkg::*;

module imem_bytes #(
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 256,
  parameter int INSTR_BYTES = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [7:0]                    wdata,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             raddr,
  output logic [instr_w(INSTR_BYTES)-1:0] rdata
);

  localparam int MW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [MW-1:0] widx, ridx;

  assign widx = waddr[MW-1:0];
  assign ridx = raddr[MW-1:0];

  // Upper address bits are discarded: the array aliases modulo its depth.
  logic unused_hi;
  assign unused_hi = ^{waddr[ADDR_W-1:MW], raddr[ADDR_W-1:MW]};

  always_ff @(posedge clock) begin
    if (we) mem[widx] <= wdata;
  end

  // Reads see the pre-edge array, so a same-edge write returns the old byte.
  // Byte offsets add within MW bits, wrapping around the end of the array.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      for (int i = 0; i < INSTR_BYTES; i++)
        rdata[8*(INSTR_BYTES-1-i) +: 8] <= mem[ridx + MW'(i)];
    end
  end

endmodule

// File: rtl/pc_imem_fetch.sv
// Program counter + instruction fetch over a byte-loadable memory.
//   clock, reset_n            : clock, async active-low reset
//   Stall                     : freeze PC/outputs/state (loads still happen)
//   BranchTaken, BranchTarget : redirect PC, squash the fetch that edge
//   LoadEn/LoadAddr/LoadData  : program-load byte write, any state
//   PC                        : next fetch address
//   InstrPC, Instruction      : address and big-endian word of last fetch
//   Valid                     : Instruction/InstrPC meaningful
//   Fault                     : sticky misaligned (or out-of-bounds) fetch
// Build option IMEM_BOUNDS_CHECK_EN: fault when any fetched byte address is
// beyond DEPTH_BYTES; otherwise fetch addresses wrap modulo DEPTH_BYTES.
import pc_imem_pkg::*;

module pc_imem_fetch #(
  parameter int              ADDR_W      = 64,
  parameter int              DEPTH_BYTES = 256,
  parameter int              INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            Stall,
  input  logic                            BranchTaken,
  input  logic [ADDR_W-1:0]               BranchTarget,
  input  logic                            LoadEn,
  input  logic [ADDR_W-1:0]               LoadAddr,
  input  logic [7:0]                      LoadData,
  output logic [ADDR_W-1:0]               PC,
  output logic [ADDR_W-1:0]               InstrPC,
  output logic [instr_w(INSTR_BYTES)-1:0] Instruction,
  output logic                            Valid,
  output logic                            Fault
);

  localparam int                OFF_W    = off_w(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc_n, ipc_n;
  logic              vld_n, flt_n, fetch, misalign, oob;

  assign misalign = |(PC & OFF_MASK);

`ifdef IMEM_BOUNDS_CHECK_EN
  // Aligned PC: the last byte is in range iff PC <= DEPTH-INSTR_BYTES.
  assign oob = PC > ADDR_W'(DEPTH_BYTES - INSTR_BYTES);
`else
  assign oob = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      PC      <= RESET_PC;
      InstrPC <= '0;
      Valid   <= 1'b0;
      Fault   <= 1'b0;
    end else begin
      state   <= state_n;
      PC      <= pc_n;
      InstrPC <= ipc_n;
      Valid   <= vld_n;
      Fault   <= flt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = PC;
    ipc_n   = InstrPC;
    vld_n   = Valid;
    flt_n   = Fault;
    fetch   = 1'b0;
    case (state)
      IDLE: if (!Stall) begin
        state_n = FETCH;
        vld_n   = 1'b0;
      end
      FETCH: if (!Stall) begin
        if (BranchTaken) begin
          pc_n  = BranchTarget;
          vld_n = 1'b0;
        end else if (misalign || oob) begin
          state_n = FAULT;
          flt_n   = 1'b1;
          vld_n   = 1'b0;
        end else begin
          fetch = 1'b1;
          ipc_n = PC;
          vld_n = 1'b1;
          pc_n  = PC + STEP;
        end
      end
      FAULT: ;
      default: state_n = IDLE;
    endcase
  end

  imem_bytes #(
    .ADDR_W     (ADDR_W),
    .DEPTH_BYTES(DEPTH_BYTES),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_mem (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (LoadEn),
    .waddr  (LoadAddr),
    .wdata  (LoadData),
    .re     (fetch),
    .raddr  (PC),
    .rdata  (Instruction)
  );

endmodule
